// File: rtl/ram_bus_bridge_pkg.sv
// ram_bus_bridge_pkg: shared widths, FSM state encoding and timeout fill pattern
// Contents: ADDR_BUS/DATA_BUS default widths, state_t (IDLE/REQ/WAIT/DONE), TIMEOUT_FILL
package ram_bus_bridge_pkg;
    localparam int ADDR_BUS = 64;
    localparam int DATA_BUS = 64;
    localparam logic [63:0] TIMEOUT_FILL = 64'hDEAD_BEEF_DEAD_BEEF;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/ram_bus_bridge_watchdog.sv
// ram_bus_bridge_watchdog: response watchdog counter, built only with BRIDGE_TIMEOUT_EN
// Ports: clk, rst (async, active-high), clr (zero the count), en (count this cycle),
//        expired (high while enabled with the count at LIMIT-1)
`ifdef BRIDGE_TIMEOUT_EN
module ram_bus_bridge_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(LIMIT) > 0 ? $clog2(LIMIT) : 1;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    assign expired = en && (cnt == CW'(LIMIT - 1));
endmodule
`endif

// File: rtl/ram_bus_bridge.sv
// ram_bus_bridge: turns single-cycle core RAM strobes into a valid/ready memory transaction
// Ports: clk, rst (async, active-high); core side core_rd_en/core_rd_addr,
//        core_wr_en/core_wr_addr/core_wr_data/core_wr_mask -> core_rd_data/core_rd_valid/core_lock;
//        memory side mem_req_valid/ready/we/addr/wdata/wmask, mem_resp_valid/rdata; bus_err.
// Optional: define BRIDGE_TIMEOUT_EN to build the response watchdog and sticky bus_err.
module ram_bus_bridge
    import ram_bus_bridge_pkg::*;
#(
    parameter int ADDR_W         = ADDR_BUS,
    parameter int DATA_W         = DATA_BUS,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_rd_en,
    input  logic [ADDR_W-1:0] core_rd_addr,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_wr_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    input  logic [DATA_W-1:0] core_wr_mask,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_rd_valid,
    output logic              core_lock,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [DATA_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              bus_err
);
    state_t state, state_n;
    logic [ADDR_W-1:0] addr_q, rd_addr_q;
    logic [DATA_W-1:0] wdata_q, wmask_q;
    logic we_q, pend_rd, timeout;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = (core_rd_en || core_wr_en) ? REQ : IDLE;
            REQ:  state_n = timeout ? DONE : (mem_req_ready ? WAIT : REQ);
            WAIT: state_n = timeout ? DONE : (!mem_resp_valid ? WAIT : ((we_q && pend_rd) ? REQ : DONE));
            default: state_n = IDLE;
        endcase
        mem_req_valid = state == REQ;
        core_lock     = state == IDLE ? (core_rd_en || core_wr_en) : state != DONE;
        core_rd_valid = state == DONE && !we_q;
    end

    // A combined write+read runs the write first; the read address waits in rd_addr_q.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            addr_q       <= '0;
            rd_addr_q    <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            we_q         <= 1'b0;
            pend_rd      <= 1'b0;
            core_rd_data <= '0;
        end else if (state == IDLE && core_wr_en) begin
            addr_q  <= core_wr_addr;
            wdata_q <= core_wr_data;
            wmask_q <= core_wr_mask;
            we_q    <= 1'b1;
            pend_rd <= core_rd_en;
            if (core_rd_en)
                rd_addr_q <= core_rd_addr;
        end else if (state == IDLE && core_rd_en) begin
            addr_q  <= core_rd_addr;
            we_q    <= 1'b0;
            pend_rd <= 1'b0;
        end else if ((state == REQ || state == WAIT) && timeout) begin
            core_rd_data <= DATA_W'(TIMEOUT_FILL);
            pend_rd      <= 1'b0;
        end else if (state == WAIT && mem_resp_valid) begin
            if (we_q && pend_rd) begin
                pend_rd <= 1'b0;
                addr_q  <= rd_addr_q;
                we_q    <= 1'b0;
            end else if (!we_q)
                core_rd_data <= mem_resp_rdata;
        end

    assign mem_req_we    = we_q;
    assign mem_req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

`ifdef BRIDGE_TIMEOUT_EN
    logic err_q;
    ram_bus_bridge_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != REQ && state_n == REQ),
        .en      (state == REQ || state == WAIT),
        .expired (timeout)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst)
            err_q <= 1'b0;
        else if (timeout)
            err_q <= 1'b1;
    assign bus_err = err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif
endmodule

// File: tb/tb_ram_bus_bridge.sv
// tb_ram_bus_bridge: scoreboard bench for ram_bus_bridge with a configurable memory responder
module tb_ram_bus_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        core_rd_en, core_wr_en;
    logic [63:0] core_rd_addr, core_wr_addr, core_wr_data, core_wr_mask;
    logic [63:0] core_rd_data;
    logic        core_rd_valid, core_lock;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata, mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        bus_err;

    ram_bus_bridge #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr),
        .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr),
        .core_wr_data(core_wr_data), .core_wr_mask(core_wr_mask),
        .core_rd_data(core_rd_data), .core_rd_valid(core_rd_valid), .core_lock(core_lock),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] wmask;
    } req_t;

    req_t        req_q[$];
    logic [63:0] rd_q[$];
    logic [63:0] resp_data_q[$];
    int n_cmp = 0, n_err = 0, rd_pulses = 0;
    int rdy_dly = 0, resp_dly = 0;
    int lk, lk2;
    logic rsp_wr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input logic we, input logic [63:0] addr, wdata, wmask);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.wmask = wmask;
        return r;
    endfunction

    // Monitor: requests are checked every cycle they are presented (stability) and popped on accept.
    always @(negedge clk) if (!rst) begin
        if (mem_req_valid) begin
            if (req_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_req: got request addr %h we %b, expected none", mem_req_addr, mem_req_we);
            end else begin
                chk("req_we", {63'd0, mem_req_we}, {63'd0, req_q[0].we});
                chk("req_addr", mem_req_addr, req_q[0].addr);
                if (req_q[0].we) begin
                    chk("req_wdata", mem_req_wdata, req_q[0].wdata);
                    chk("req_wmask", mem_req_wmask, req_q[0].wmask);
                end
                if (mem_req_ready) void'(req_q.pop_front());
            end
        end
        if (core_rd_valid) begin
            rd_pulses++;
            if (rd_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_rd_valid: got data %h, expected no pulse", core_rd_data);
            end else
                chk("rd_data", core_rd_data, rd_q.pop_front());
        end
    end

    // Memory responder: ready after rdy_dly REQ cycles, response resp_dly cycles into WAIT (-1 = never).
    initial begin
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        forever begin
            if (mem_req_valid && !rst) begin
                repeat (rdy_dly) begin @(posedge clk); #1; end
                rsp_wr = mem_req_we;
                mem_req_ready = 1'b1;
                @(posedge clk); #1;
                mem_req_ready = 1'b0;
                if (resp_dly >= 0) begin
                    repeat (resp_dly) begin @(posedge clk); #1; end
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = (!rsp_wr && resp_data_q.size() > 0) ? resp_data_q.pop_front() : 64'd0;
                    @(posedge clk); #1;
                    mem_resp_valid = 1'b0;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    task automatic summary_and_fatal(input string why);
        n_cmp++; n_err++;
        $display("FAIL %s: got no completion, expected core_lock release", why);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "aborted");
    endtask

    // Drives one core access and returns at the negedge of the DONE cycle with the locked-cycle count.
    task automatic access(input logic wr, rd, input logic [63:0] waddr, wdata, wmask, raddr, output int locked);
        core_wr_en = wr; core_rd_en = rd;
        core_wr_addr = waddr; core_wr_data = wdata; core_wr_mask = wmask; core_rd_addr = raddr;
        #1;
        locked = core_lock ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!core_lock) return;
            locked++;
        end
        summary_and_fatal("access_timeout");
    endtask

    task automatic idle();
        core_rd_en = 1'b0; core_wr_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        summary_and_fatal("global_timeout");
    end

    initial begin
        rst = 1'b1;
        core_rd_en = 0; core_wr_en = 0;
        core_rd_addr = 0; core_wr_addr = 0; core_wr_data = 0; core_wr_mask = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_lock", {63'd0, core_lock}, 64'd0);
        chk("rst_rd_valid", {63'd0, core_rd_valid}, 64'd0);
        chk("rst_rd_data", core_rd_data, 64'd0);
        chk("rst_req_addr", mem_req_addr, 64'd0);
        chk("rst_bus_err", {63'd0, bus_err}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single read, minimum latency, unaligned address
        rdy_dly = 0; resp_dly = 0;
        req_q.push_back(mk(0, 64'h8000_0010, 0, 0));
        resp_data_q.push_back(64'h1122_3344_5566_7788);
        rd_q.push_back(64'h1122_3344_5566_7788);
        access(0, 1, 0, 0, 0, 64'h8000_0014, lk);
        chk("rd_lock_cycles", lk, 3);
        chk("rd_data_done", core_rd_data, 64'h1122_3344_5566_7788);
        idle();

        // Write with ready held low 4 cycles
        rdy_dly = 4; resp_dly = 0;
        req_q.push_back(mk(1, 64'h8000_0008, 64'hAA, 64'hFF));
        access(1, 0, 64'h8000_0008, 64'hAA, 64'hFF, 0, lk);
        chk("wr_lock_cycles", lk, 7);
        chk("wr_no_rd_valid", {63'd0, core_rd_valid}, 64'd0);
        idle();
        chk("rd_data_hold", core_rd_data, 64'h1122_3344_5566_7788);
        chk("pulses_after_wr", rd_pulses, 1);

        // Simultaneous write and read: write first
        rdy_dly = 0; resp_dly = 0;
        req_q.push_back(mk(1, 64'h8000_0000, 64'h55, 64'hFFFF));
        req_q.push_back(mk(0, 64'h8000_0040, 0, 0));
        resp_data_q.push_back(64'hCAFE_F00D_1234_5678);
        rd_q.push_back(64'hCAFE_F00D_1234_5678);
        access(1, 1, 64'h8000_0000, 64'h55, 64'hFFFF, 64'h8000_0040, lk);
        chk("wr_rd_lock_cycles", lk, 5);
        idle();
        chk("pulses_after_wr_rd", rd_pulses, 2);

        // Back-to-back reads: next read presented in the DONE cycle
        req_q.push_back(mk(0, 64'h8000_0100, 0, 0));
        req_q.push_back(mk(0, 64'h8000_0208, 0, 0));
        resp_data_q.push_back(64'h0101_0101_0101_0101);
        resp_data_q.push_back(64'h0202_0202_0202_0202);
        rd_q.push_back(64'h0101_0101_0101_0101);
        rd_q.push_back(64'h0202_0202_0202_0202);
        access(0, 1, 0, 0, 0, 64'h8000_0100, lk);
        access(0, 1, 0, 0, 0, 64'h8000_020C, lk2);
        chk("b2b_lock_first", lk, 3);
        chk("b2b_lock_second", lk2, 3);
        idle();
        repeat (3) @(negedge clk);
        chk("b2b_req_drained", req_q.size(), 0);
        chk("pulses_after_b2b", rd_pulses, 4);

        // Reset during WAIT, late response ignored
        rdy_dly = 0; resp_dly = 3;
        req_q.push_back(mk(0, 64'h8000_0300, 0, 0));
        resp_data_q.push_back(64'h0BAD_0BAD_0BAD_0BAD);
        core_rd_en = 1'b1; core_rd_addr = 64'h8000_0300;
        @(negedge clk);
        @(negedge clk);
        chk("wait_lock", {63'd0, core_lock}, 64'd1);
        chk("wait_req_valid", {63'd0, mem_req_valid}, 64'd0);
        rst = 1'b1; core_rd_en = 1'b0;
        #1;
        chk("midrst_lock", {63'd0, core_lock}, 64'd0);
        chk("midrst_rd_data", core_rd_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("postrst_rd_valid", {63'd0, core_rd_valid}, 64'd0);
            chk("postrst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        end
        chk("postrst_rd_data", core_rd_data, 64'd0);
        chk("postrst_resp_used", resp_data_q.size(), 0);

`ifdef BRIDGE_TIMEOUT_EN
        // No response: watchdog forces completion
        rdy_dly = 0; resp_dly = -1;
        req_q.push_back(mk(0, 64'h8000_0400, 0, 0));
        rd_q.push_back(64'hDEAD_BEEF_DEAD_BEEF);
        access(0, 1, 0, 0, 0, 64'h8000_0400, lk);
        chk("to_bus_err", {63'd0, bus_err}, 64'd1);
        chk("to_rd_data", core_rd_data, 64'hDEAD_BEEF_DEAD_BEEF);
        idle();
        chk("to_lock_released", {63'd0, core_lock}, 64'd0);
        chk("to_pulses", rd_pulses, 5);
`else
        chk("no_timeout_bus_err", {63'd0, bus_err}, 64'd0);
        chk("final_pulses", rd_pulses, 4);
`endif
        repeat (3) @(negedge clk);
        chk("req_q_left", req_q.size(), 0);
        chk("rd_q_left", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ram_bus_bridge.md
Name: ram_bus_bridge

Overview:
Sits directly downstream of the core's data-memory port. Converts the core's single-cycle RAM read/write strobes (RamReadEnable/RamReadAddr, RamWriteEnable/RamWriteAddr/RamWriteData/RamWriteMask) into a valid/ready request plus response-valid memory transaction with variable latency. Drives core_lock into the ctrl CoreLock input so the pipeline stalls until the access completes. Serialises a simultaneous write and read, write first.

Parameters:
ADDR_W, 64, address width of core and memory sides
DATA_W, 64, data and mask width
TIMEOUT_CYCLES, 1024, response watchdog limit in cycles (used only with BRIDGE_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset; asynchronous, active-high
core_rd_en  in  1  core read request (RamReadEnable)
core_rd_addr  in  ADDR_W  read byte address
core_wr_en  in  1  core write request (RamWriteEnable)
core_wr_addr  in  ADDR_W  write byte address
core_wr_data  in  DATA_W  write data
core_wr_mask  in  DATA_W  bit-level write mask
core_rd_data  out  DATA_W  read data (RamReadData)
core_rd_valid  out  1  read data valid, one-cycle pulse
core_lock  out  1  stall request to ctrl CoreLock
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 = write, 0 = read
mem_req_addr  out  ADDR_W  8-byte-aligned address (low 3 bits zero)
mem_req_wdata  out  DATA_W  write data
mem_req_wmask  out  DATA_W  write mask
mem_resp_valid  in  1  response or write acknowledge
mem_resp_rdata  in  DATA_W  read response data
bus_err  out  1  sticky timeout error (BRIDGE_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset values: state IDLE; all request registers 0; mem_req_valid=0; core_rd_valid=0; core_rd_data=0; bus_err=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - core_lock = core_rd_en | core_wr_en (combinational).
  - If core_wr_en: capture the write fields; capture the read fields if core_rd_en; set pend_rd = core_rd_en; issue the write; go to REQ.
  - Else if core_rd_en: capture the read address; go to REQ.
- REQ:
  - mem_req_valid=1. Address, data, mask and we are held stable from registers until mem_req_ready.
  - On valid & ready: go to WAIT. Request accepted in the first REQ cycle gives minimum latency.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid after a write: if pend_rd, clear pend_rd, load the read address, we=0, go to REQ; else go to DONE.
  - On mem_resp_valid after a read: latch mem_resp_rdata into core_rd_data; go to DONE.
- DONE:
  - core_lock=0. core_rd_valid=1 for this single cycle if the last access was a read.
  - Core request inputs are ignored in this cycle (they still reflect the completed access). Next state IDLE.
- core_lock = 1 in REQ and WAIT.
- core_rd_data holds its value until the next read completes.
- mem_resp_valid is ignored outside WAIT. mem_req_ready is ignored outside REQ.
- Minimum latency for a read with ready=1 and a response on the following cycle: 3 locked cycles, data visible in the DONE cycle.
- Reset mid-operation: immediate return to IDLE and mem_req_valid drops. A late response arriving after reset is ignored.
- Address alignment: mem_req_addr = captured_addr & ~7.

Optional Feature:
BRIDGE_TIMEOUT_EN:
- Defined: a counter clears on entry to REQ and increments in REQ and WAIT. On reaching TIMEOUT_CYCLES - 1:
  - set sticky bus_err;
  - force DONE with core_rd_data = 64'hDEAD_BEEF_DEAD_BEEF;
  - drop any pending read.
  bus_err clears only on rst.
- Undefined: no counter is built, bus_err = 0, and the bridge waits indefinitely.

Decomposition:
- State encodings (2-bit IDLE/REQ/WAIT/DONE) and the timeout fill pattern go in the shared defines.v.
- ADDR_BUS/DATA_BUS widths are reused from defines.v.
- One natural sub-module: bridge_watchdog, the timeout counter with clear, enable and expire. It is instantiated only under BRIDGE_TIMEOUT_EN.

Test Plan:
- Read 0x8000_0014, ready=1, response 0x1122334455667788 one cycle later -> mem_req_addr=0x8000_0010, core_lock high 3 cycles, core_rd_valid pulse with that data.
- Write 0x8000_0008, data 0xAA, mask 0xFF, ready held low 4 cycles -> mem_req_valid and fields stable for all 5 cycles, we=1, core_lock released 1 cycle after the acknowledge, core_rd_valid stays 0.
- Simultaneous write 0x8000_0000 and read 0x8000_0040 -> write request first, then read request, one core_rd_valid, core_lock continuous until DONE.
- rst asserted during WAIT, response arrives 2 cycles after rst deasserts -> outputs return to reset values, response ignored, core_rd_valid stays 0.
- BRIDGE_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no response -> bus_err=1 after 16 locked cycles, core_rd_data=0xDEADBEEFDEADBEEF, lock released.
- Back-to-back reads on consecutive instructions -> second request is accepted only from IDLE after DONE, no duplicated request.
